// File: rtl/pong_game_ctrl_if.sv
// Bus between the key decode / frame timing side and the game controller.
// master: drives frame_tick, start and the four key levels; reads object state.
// slave : the controller; reads ticks/keys, drives paddle/ball coordinates,
//         scores, game_state and point_pulse.
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       w_in;
  logic       s_in;
  logic       o_in;
  logic       l_in;
  logic [8:0] paddle_l_y;
  logic [8:0] paddle_r_y;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [2:0] game_state;
  logic       point_pulse;

  modport master (
    output frame_tick, start, w_in, s_in, o_in, l_in,
    input  paddle_l_y, paddle_r_y, ball_x, ball_y,
           score_l, score_r, game_state, point_pulse
  );

  modport slave (
    input  frame_tick, start, w_in, s_in, o_in, l_in,
    output paddle_l_y, paddle_r_y, ball_x, ball_y,
           score_l, score_r, game_state, point_pulse
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: advances paddles, ball, scores and serve timing once per
// VGA frame tick and presents registered object coordinates to the renderer.
// Ports:
//   clock - system clock
//   reset - asynchronous, active-high reset
//   bus   - slave side of pong_game_ctrl_if (tick/start/keys in, game state out)
module pong_game_ctrl #(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned PADDLE_W     = 8,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned PADDLE_L_X   = 16,
  parameter int unsigned PADDLE_R_X   = 616,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic            clock,
  input  logic            reset,
  pong_game_ctrl_if.slave bus
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = $clog2(SERVE_FRAMES);

  localparam logic [YW-1:0] PADDLE_MAX  = YW'(SCREEN_H - PADDLE_H);
  localparam logic [YW-1:0] PADDLE_MID  = YW'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [YW-1:0] PAD_STEP    = YW'(PADDLE_SPEED);
  localparam logic [XW-1:0] BALL_X_MID  = XW'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [YW-1:0] BALL_Y_MID  = YW'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [XW-1:0] BALL_X_MAX  = XW'(SCREEN_W - BALL_SIZE);
  localparam logic [YW-1:0] BALL_Y_MAX  = YW'(SCREEN_H - BALL_SIZE);
  localparam logic [XW-1:0] STEP_X      = XW'(BALL_SPEED);
  localparam logic [YW-1:0] STEP_Y      = YW'(BALL_SPEED);
  localparam logic [XW-1:0] HIT_L_X     = XW'(PADDLE_L_X + PADDLE_W);
  localparam logic [XW-1:0] HIT_R_X     = XW'(PADDLE_R_X - BALL_SIZE);
  localparam logic [SW-1:0] WIN         = SW'(WIN_SCORE);
  localparam logic [CW-1:0] SERVE_LAST  = CW'(SERVE_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_SCORE     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [YW-1:0] paddle_l_q, paddle_l_d;
  logic [YW-1:0] paddle_r_q, paddle_r_d;
  logic [XW-1:0] ball_x_q, ball_x_d;
  logic [YW-1:0] ball_y_q, ball_y_d;
  logic [SW-1:0] score_l_q, score_l_d;
  logic [SW-1:0] score_r_q, score_r_d;
  logic          dir_x_q, dir_x_d;     // 1 = moving right (+x)
  logic          dir_y_q, dir_y_d;     // 1 = moving down (+y)
  logic [CW-1:0] serve_cnt_q, serve_cnt_d;
  logic          scorer_l_q, scorer_l_d;  // who won the pending point
  logic          point_pulse_q, point_pulse_d;
  logic [SW-1:0] score_new;

  // Saturating paddle step; both or neither key means no move.
  function automatic logic [YW-1:0] move_paddle(input logic [YW-1:0] y,
                                                input logic up,
                                                input logic dn);
    logic [YW-1:0] r;
    r = y;
    if (up && !dn) begin
      r = (y < PAD_STEP) ? '0 : y - PAD_STEP;
    end else if (dn && !up) begin
      r = (y >= PADDLE_MAX - PAD_STEP) ? PADDLE_MAX : y + PAD_STEP;
    end
    return r;
  endfunction

  // Vertical overlap of ball and paddles, widened so the sums cannot wrap.
  logic [YW:0] ball_bot, pl_bot, pr_bot;
  logic        overlap_l, overlap_r;
  logic        hit_l, hit_r, miss_l, miss_r;

  assign ball_bot  = {1'b0, ball_y_q} + (YW+1)'(BALL_SIZE);
  assign pl_bot    = {1'b0, paddle_l_q} + (YW+1)'(PADDLE_H);
  assign pr_bot    = {1'b0, paddle_r_q} + (YW+1)'(PADDLE_H);
  assign overlap_l = (ball_bot > {1'b0, paddle_l_q}) && ({1'b0, ball_y_q} < pl_bot);
  assign overlap_r = (ball_bot > {1'b0, paddle_r_q}) && ({1'b0, ball_y_q} < pr_bot);

  // Contact windows: the ball is at or just outside the paddle face and would
  // reach or cross it this frame.
  assign hit_l  = !dir_x_q && (ball_x_q >= HIT_L_X) &&
                  (ball_x_q <= HIT_L_X + STEP_X) && overlap_l;
  assign hit_r  = dir_x_q && (ball_x_q <= HIT_R_X) &&
                  (ball_x_q >= HIT_R_X - STEP_X) && overlap_r;
  assign miss_l = !dir_x_q && (ball_x_q < STEP_X);
  assign miss_r = dir_x_q && (ball_x_q > BALL_X_MAX - STEP_X);

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      paddle_l_q    <= PADDLE_MID;
      paddle_r_q    <= PADDLE_MID;
      ball_x_q      <= BALL_X_MID;
      ball_y_q      <= BALL_Y_MID;
      score_l_q     <= '0;
      score_r_q     <= '0;
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      serve_cnt_q   <= '0;
      scorer_l_q    <= 1'b0;
      point_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddle_l_q    <= paddle_l_d;
      paddle_r_q    <= paddle_r_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      serve_cnt_q   <= serve_cnt_d;
      scorer_l_q    <= scorer_l_d;
      point_pulse_q <= point_pulse_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    paddle_l_d    = paddle_l_q;
    paddle_r_d    = paddle_r_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    serve_cnt_d   = serve_cnt_q;
    scorer_l_d    = scorer_l_q;
    point_pulse_d = 1'b0;
    score_new     = '0;

    if (bus.frame_tick && (state_q != ST_GAME_OVER)) begin
      paddle_l_d = move_paddle(paddle_l_q, bus.w_in, bus.s_in);
      paddle_r_d = move_paddle(paddle_r_q, bus.o_in, bus.l_in);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_SERVE;
          score_l_d   = '0;
          score_r_d   = '0;
          serve_cnt_d = '0;
        end
      end

      ST_SERVE: begin
        if (bus.frame_tick) begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + CW'(1);
          end
        end
      end

      ST_PLAY: begin
        if (bus.frame_tick) begin
          // Vertical bounce off top/bottom walls.
          if (!dir_y_q && (ball_y_q < STEP_Y)) begin
            ball_y_d = '0;
            dir_y_d  = 1'b1;
          end else if (dir_y_q && (ball_y_q > BALL_Y_MAX - STEP_Y)) begin
            ball_y_d = BALL_Y_MAX;
            dir_y_d  = 1'b0;
          end else if (dir_y_q) begin
            ball_y_d = ball_y_q + STEP_Y;
          end else begin
            ball_y_d = ball_y_q - STEP_Y;
          end

          // Paddle contact wins over a miss on the same frame.
          if (hit_l) begin
            ball_x_d = HIT_L_X;
            dir_x_d  = 1'b1;
          end else if (hit_r) begin
            ball_x_d = HIT_R_X;
            dir_x_d  = 1'b0;
          end else if (miss_l) begin
            scorer_l_d    = 1'b0;
            state_d       = ST_SCORE;
            point_pulse_d = 1'b1;
          end else if (miss_r) begin
            scorer_l_d    = 1'b1;
            state_d       = ST_SCORE;
            point_pulse_d = 1'b1;
          end else if (dir_x_q) begin
            ball_x_d = ball_x_q + STEP_X;
          end else begin
            ball_x_d = ball_x_q - STEP_X;
          end
        end
      end

      ST_SCORE: begin
        if (scorer_l_q) begin
          score_new = (score_l_q < WIN) ? score_l_q + SW'(1) : score_l_q;
          score_l_d = score_new;
        end else begin
          score_new = (score_r_q < WIN) ? score_r_q + SW'(1) : score_r_q;
          score_r_d = score_new;
        end
        if (score_new == WIN) begin
          state_d = ST_GAME_OVER;
        end else begin
          // Next serve heads toward the player who conceded.
          state_d     = ST_SERVE;
          ball_x_d    = BALL_X_MID;
          ball_y_d    = BALL_Y_MID;
          dir_x_d     = scorer_l_q;
          serve_cnt_d = '0;
        end
      end

      ST_GAME_OVER: begin
        if (bus.start) begin
          state_d     = ST_SERVE;
          score_l_d   = '0;
          score_r_d   = '0;
          ball_x_d    = BALL_X_MID;
          ball_y_d    = BALL_Y_MID;
          dir_x_d     = 1'b1;
          serve_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.paddle_l_y  = paddle_l_q;
  assign bus.paddle_r_y  = paddle_r_q;
  assign bus.ball_x      = ball_x_q;
  assign bus.ball_y      = ball_y_q;
  assign bus.score_l     = score_l_q;
  assign bus.score_r     = score_r_q;
  assign bus.game_state  = state_q;
  assign bus.point_pulse = point_pulse_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: stimulus pushes the expected outputs of
// a behavioural game model; a monitor pops and compares after each clock edge.
module tb_pong_game_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  pong_game_ctrl_if bus();

  pong_game_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pl; int pr; int bx; int by; int sl; int sr; int st; int pulse;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Behavioural game model (plain integers, signed directions).
  int m_pl, m_pr, m_bx, m_by, m_sl, m_sr, m_st, m_pulse, m_dx, m_dy, m_cnt;
  bit m_left_scored;
  int n_game_over = 0;
  int n_hits = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pl = 208; m_pr = 208; m_bx = 316; m_by = 236;
    m_sl = 0; m_sr = 0; m_st = 0; m_pulse = 0;
    m_dx = 1; m_dy = 1; m_cnt = 0; m_left_scored = 0;
  endtask

  function automatic int paddle_move(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
    if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  function automatic bit overlaps(input int by, input int py);
    return (by + 8 > py) && (by < py + 64);
  endfunction

  task automatic model_step(input bit t, input bit st, input bit w, input bit s,
                            input bit o, input bit l);
    int npl, npr, nby, ndy;
    bit won;
    m_pulse = 0;
    npl = m_pl;
    npr = m_pr;
    if (t && m_st != 4) begin
      npl = paddle_move(m_pl, w, s);
      npr = paddle_move(m_pr, o, l);
    end
    case (m_st)
      0: if (st) begin m_st = 1; m_sl = 0; m_sr = 0; m_cnt = 0; end
      1: if (t) begin
           if (m_cnt == 59) begin m_st = 2; m_cnt = 0; end
           else m_cnt++;
         end
      2: if (t) begin
           nby = m_by + 2 * m_dy;
           ndy = m_dy;
           if (nby < 0)   begin nby = 0;   ndy = 1;  end
           if (nby > 472) begin nby = 472; ndy = -1; end
           if (m_dx < 0 && m_bx - 2 <= 24 && m_bx >= 24 && overlaps(m_by, m_pl)) begin
             m_bx = 24; m_dx = 1; n_hits++;
           end else if (m_dx > 0 && m_bx + 2 >= 608 && m_bx <= 608 && overlaps(m_by, m_pr)) begin
             m_bx = 608; m_dx = -1; n_hits++;
           end else if (m_dx < 0 && m_bx < 2) begin
             m_left_scored = 0; m_st = 3; m_pulse = 1;
           end else if (m_dx > 0 && m_bx + 2 > 632) begin
             m_left_scored = 1; m_st = 3; m_pulse = 1;
           end else begin
             m_bx = m_bx + 2 * m_dx;
           end
           m_by = nby;
           m_dy = ndy;
         end
      3: begin
           if (m_left_scored) begin
             if (m_sl < 7) m_sl++;
             won = (m_sl == 7);
           end else begin
             if (m_sr < 7) m_sr++;
             won = (m_sr == 7);
           end
           if (won) begin
             m_st = 4; n_game_over++;
           end else begin
             m_st = 1; m_bx = 316; m_by = 236; m_cnt = 0;
             m_dx = m_left_scored ? 1 : -1;
           end
         end
      4: if (st) begin
           m_st = 1; m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236;
           m_dx = 1; m_cnt = 0;
         end
      default: ;
    endcase
    m_pl = npl;
    m_pr = npr;
  endtask

  task automatic push_expected();
    exp_t e;
    e.pl = m_pl; e.pr = m_pr; e.bx = m_bx; e.by = m_by;
    e.sl = m_sl; e.sr = m_sr; e.st = m_st; e.pulse = m_pulse;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus: drive at the falling edge, predict the next edge.
  task automatic step(input bit t, input bit st, input bit w, input bit s,
                      input bit o, input bit l);
    @(negedge clock);
    bus.frame_tick = t; bus.start = st;
    bus.w_in = w; bus.s_in = s; bus.o_in = o; bus.l_in = l;
    model_step(t, st, w, s, o, l);
    push_expected();
  endtask

  task automatic drive_idle();
    bus.frame_tick = 0; bus.start = 0;
    bus.w_in = 0; bus.s_in = 0; bus.o_in = 0; bus.l_in = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_paddle_l_y"}, int'(bus.paddle_l_y), 208);
    check({tag, "_paddle_r_y"}, int'(bus.paddle_r_y), 208);
    check({tag, "_ball_x"},     int'(bus.ball_x), 316);
    check({tag, "_ball_y"},     int'(bus.ball_y), 236);
    check({tag, "_score_l"},    int'(bus.score_l), 0);
    check({tag, "_score_r"},    int'(bus.score_r), 0);
    check({tag, "_state"},      int'(bus.game_state), 0);
    check({tag, "_point"},      int'(bus.point_pulse), 0);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    drive_idle();
    #1 check_reset_values("async_rst");
    model_reset();
    exp_q.delete();
    push_expected();
    @(negedge clock);
    reset = 1'b0;
    model_step(0, 0, 0, 0, 0, 0);
    push_expected();
  endtask

  // Monitor: compare every predicted edge just after it happens.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("paddle_l_y",  int'(bus.paddle_l_y),  e.pl);
        check("paddle_r_y",  int'(bus.paddle_r_y),  e.pr);
        check("ball_x",      int'(bus.ball_x),      e.bx);
        check("ball_y",      int'(bus.ball_y),      e.by);
        check("score_l",     int'(bus.score_l),     e.sl);
        check("score_r",     int'(bus.score_r),     e.sr);
        check("game_state",  int'(bus.game_state),  e.st);
        check("point_pulse", int'(bus.point_pulse), e.pulse);
      end
    end
  end

  // Key choice for a player: 0 random, 1 track the ball, 2 hands off.
  function automatic void pick_keys(input int mode, input int py,
                                    output bit up, output bit dn);
    int pc, bc;
    up = 0; dn = 0;
    if (mode == 0) begin
      up = 1'($urandom_range(0, 1));
      dn = 1'($urandom_range(0, 1));
    end else if (mode == 1) begin
      pc = py + 32;
      bc = m_by + 4;
      if (bc < pc - 4) up = 1;
      else if (bc > pc + 4) dn = 1;
    end
  endfunction

  initial begin
    int mode_l, mode_r;
    bit w, s, o, l, t, st;
    bit did_play_reset;
    drive_idle();
    model_reset();
    did_play_reset = 0;
    repeat (2) @(negedge clock);
    check_reset_values("por");
    reset = 1'b0;

    // Idle frames, then paddle saturation at both ends and both-keys hold.
    repeat (3)   step(1, 0, 0, 0, 0, 0);
    repeat (60)  step(1, 0, 1, 0, 0, 0);
    repeat (120) step(1, 0, 0, 1, 1, 0);
    repeat (10)  step(1, 0, 1, 1, 0, 1);
    repeat (5)   step(0, 0, 1, 0, 1, 0);

    // Start, full serve delay, first ball move.
    step(0, 1, 0, 0, 0, 0);
    repeat (60) step(1, 0, 0, 0, 0, 0);
    repeat (3)  step(1, 0, 0, 0, 0, 0);

    // Randomised play with alternating player behaviours.
    mode_l = 1; mode_r = 0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      if (cyc % 500 == 0) begin
        mode_l = $urandom_range(0, 2);
        mode_r = $urandom_range(0, 2);
      end
      if ((!did_play_reset && m_st == 2 && cyc > 20000) ||
          ($urandom_range(0, 9999) == 0)) begin
        if (m_st == 2) did_play_reset = 1;
        do_reset();
        step(0, 1, 0, 0, 0, 0);
      end else begin
        pick_keys(mode_l, m_pl, w, s);
        pick_keys(mode_r, m_pr, o, l);
        t  = ($urandom_range(0, 3) != 0);
        st = (m_st == 4) ? ($urandom_range(0, 29) == 0)
                         : ($urandom_range(0, 299) == 0);
        step(t, st, w, s, o, l);
      end
    end

    @(negedge clock);
    drive_idle();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
